// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: registers raw deserializer words, decodes 8b data or
// control tokens, and owns word alignment by pulsing bitslip until token runs lock.
module tmds_channel_decoder #(
  parameter int unsigned CTKN_CNT  = 64,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned SLIP_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_cnt,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de
);

  localparam int unsigned TMR_W  = $clog2(TIMEOUT) + 1;
  localparam int unsigned CTKN_W = 8;

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  WAIT_LAST = TMR_W'(SLIP_WAIT - 1);
  localparam logic [CTKN_W-1:0] CTKN_LAST = CTKN_W'(CTKN_CNT - 1);
  localparam logic [CTKN_W-1:0] CTKN_MAX  = CTKN_W'(CTKN_CNT);

  typedef enum logic [1:0] {
    S_SEARCH    = 2'd0,
    S_SLIP_WAIT = 2'd1,
    S_LOCKED    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        din_q;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CTKN_W-1:0] ctkn_q, ctkn_d;
  logic              bitslip_q, slip_d;
  logic [3:0]        slip_cnt_q, slip_cnt_d;
  logic              aligned_q;
  logic [7:0]        dout_q;
  logic              c0_q, c1_q, de_q;

  logic              tok;
  logic [1:0]        ctl;
  logic [7:0]        q_word;
  logic [7:0]        dec;

  // Control-token recognition on the registered word
  always_comb begin
    tok = 1'b0;
    ctl = 2'b00;
    case (din_q)
      10'b1101010100: begin tok = 1'b1; ctl = 2'b00; end
      10'b0010101011: begin tok = 1'b1; ctl = 2'b01; end
      10'b0101010100: begin tok = 1'b1; ctl = 2'b10; end
      10'b1010101011: begin tok = 1'b1; ctl = 2'b11; end
      default:        begin tok = 1'b0; ctl = 2'b00; end
    endcase
  end

  // TMDS data decode: undo optional inversion, then XOR/XNOR chain
  always_comb begin
    q_word   = din_q[9] ? ~din_q[7:0] : din_q[7:0];
    dec[0]   = q_word[0];
    dec[7:1] = din_q[8] ? (q_word[7:1] ^ q_word[6:0])
                        : ~(q_word[7:1] ^ q_word[6:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: begin
        // A completed token run wins over a timeout on the same cycle
        if (tok && (ctkn_q == CTKN_LAST)) begin
          state_d = S_LOCKED;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_SLIP_WAIT;
        end
      end
      S_SLIP_WAIT: begin
        if (timer_q == WAIT_LAST) begin
          state_d = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (!tok && (timer_q == TMR_LAST)) begin
          state_d = S_SEARCH;
        end
      end
      default: state_d = S_SEARCH;
    endcase
  end

  // Counter, slip and slip-count updates driven by the current transition
  always_comb begin
    timer_d    = timer_q + TMR_W'(1);
    ctkn_d     = tok ? ((ctkn_q == CTKN_MAX) ? ctkn_q : ctkn_q + CTKN_W'(1))
                     : '0;
    slip_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;
    case (state_q)
      S_SEARCH: begin
        if (state_d == S_LOCKED) begin
          timer_d = '0;
        end else if (state_d == S_SLIP_WAIT) begin
          slip_d     = 1'b1;
          slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
          timer_d    = '0;
          ctkn_d     = '0;
        end
      end
      S_SLIP_WAIT: begin
        // The deserializer output is unsettled here, so tokens are not counted
        ctkn_d = '0;
        if (state_d == S_SEARCH) begin
          timer_d = '0;
        end
      end
      S_LOCKED: begin
        if (tok) begin
          timer_d = '0;
        end else if (state_d == S_SEARCH) begin
          timer_d = '0;
          ctkn_d  = '0;
        end
      end
      default: begin
        timer_d = '0;
        ctkn_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q      <= '0;
      timer_q    <= '0;
      ctkn_q     <= '0;
      bitslip_q  <= 1'b0;
      slip_cnt_q <= '0;
      aligned_q  <= 1'b0;
      dout_q     <= '0;
      c0_q       <= 1'b0;
      c1_q       <= 1'b0;
      de_q       <= 1'b0;
    end else begin
      din_q      <= din;
      timer_q    <= timer_d;
      ctkn_q     <= ctkn_d;
      bitslip_q  <= slip_d;
      slip_cnt_q <= slip_cnt_d;
      aligned_q  <= (state_d == S_LOCKED);
      if (tok) begin
        c0_q <= ctl[0];
        c1_q <= ctl[1];
      end else begin
        dout_q <= dec;
      end
      de_q <= ~tok & (state_d == S_LOCKED);
    end
  end

  assign bitslip  = bitslip_q;
  assign aligned  = aligned_q;
  assign slip_cnt = slip_cnt_q;
  assign dout     = dout_q;
  assign c0       = c0_q;
  assign c1       = c1_q;
  assign de       = de_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomized bench for tmds_channel_decoder: a serial-stream deserializer model feeds
// the DUT, and an alignment/decode model predicts every output each cycle.
module tb_tmds_channel_decoder;

  localparam int CTKN_CNT  = 64;
  localparam int TIMEOUT   = 4096;
  localparam int SLIP_WAIT = 3;
  localparam logic [9:0] TOKENS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       bitslip;
  logic       aligned;
  logic [3:0] slip_cnt;
  logic [7:0] dout;
  logic       c0, c1, de;

  tmds_channel_decoder #(
    .CTKN_CNT (CTKN_CNT),
    .TIMEOUT  (TIMEOUT),
    .SLIP_WAIT(SLIP_WAIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .bitslip (bitslip),
    .aligned (aligned),
    .slip_cnt(slip_cnt),
    .dout    (dout),
    .c0      (c0),
    .c1      (c1),
    .de      (de)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic is_tok(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOKENS[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] tok_ctl(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == TOKENS[i]) return 2'(i);
    return 2'b00;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] w);
    logic [7:0] q, d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom); while (is_tok(w));
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: modes, run lengths and ages counted in plain integers
  localparam int M_SEARCH = 0, M_WAIT = 1, M_LOCK = 2;
  int         m_mode = M_SEARCH, m_age = 0, m_run = 0, m_left = 0, m_quiet = 0, m_slips = 0;
  logic [9:0] m_dinq = '0, m_w;
  logic [7:0] m_dout = '0;
  logic       m_c0 = 0, m_c1 = 0, m_de = 0, m_bitslip = 0, m_tok;
  bit         m_valid = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_mode = M_SEARCH; m_age = 0; m_run = 0; m_left = 0; m_quiet = 0; m_slips = 0;
      m_dinq = '0; m_dout = '0; m_c0 = 0; m_c1 = 0; m_de = 0; m_bitslip = 0;
      m_valid = 1;
    end else begin
      m_w = m_dinq;
      m_tok = is_tok(m_w);
      m_bitslip = 0;
      if (m_mode == M_SEARCH) begin
        m_age++;
        m_run = m_tok ? m_run + 1 : 0;
        if (m_run >= CTKN_CNT) begin
          m_mode = M_LOCK; m_quiet = 0;
        end else if (m_age >= TIMEOUT) begin
          m_bitslip = 1; m_slips = (m_slips + 1) % 10; m_mode = M_WAIT; m_left = SLIP_WAIT;
        end
      end else if (m_mode == M_WAIT) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_SEARCH; m_age = 0; m_run = 0; end
      end else begin
        m_quiet = m_tok ? 0 : m_quiet + 1;
        if (m_quiet >= TIMEOUT) begin m_mode = M_SEARCH; m_age = 0; m_run = 0; end
      end
      if (m_tok) {m_c1, m_c0} = tok_ctl(m_w);
      else m_dout = tmds_dec(m_w);
      m_de = !m_tok && (m_mode == M_LOCK);
      m_dinq = din;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_valid)
      check("outputs", 32'({bitslip, aligned, slip_cnt, dout, c1, c0, de}),
            32'({m_bitslip, (m_mode == M_LOCK), 4'(m_slips), m_dout, m_c1, m_c0, m_de}));
  end

  // Deserializer model: offset k taps the serial stream k bits early
  int         off = 0;
  bit         rot_en = 1;
  logic [9:0] prev_w = '0;

  task automatic send(input logic [9:0] w);
    logic [19:0] ser;
    if (rot_en && m_bitslip) off = (off + 9) % 10;
    ser = {w, prev_w};
    din = 10'(ser >> (10 - off));
    prev_w = w;
    @(negedge clk);
  endtask

  int rst_cyc = 0;
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rst_cyc = cyc;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nslip, last_slip, acnt, n;
    logic [9:0] tk;

    // Lock on an aligned token stream
    off = 0; din = TOKENS[0]; prev_w = TOKENS[0];
    do_reset();
    check("reset_outputs", 32'({bitslip, aligned, slip_cnt, dout, c1, c0, de}), 32'd0);
    for (int i = 0; i < 64; i++) send(TOKENS[0]);
    check("aligned_edge64", 32'(aligned), 32'd0);
    send(TOKENS[0]);
    check("aligned_edge65", 32'(aligned), 32'd1);
    check("lock_slip_cnt", 32'(slip_cnt), 32'd0);
    check("lock_ctl_de", 32'({c1, c0, de}), 32'd0);

    // Misaligned stream: 2000 blanking / 1280 active, starting at offset 3
    off = 3; rot_en = 1;
    do_reset();
    nslip = 0; last_slip = 0;
    for (int t = 0; t < 20000 && !aligned; t++) begin
      send(((t % 3280) < 2000) ? TOKENS[0] : rand_data());
      if (bitslip) begin
        if (nslip == 0) check("first_slip_time", 32'(cyc - rst_cyc), 32'd4096);
        else check("slip_spacing", 32'(cyc - last_slip), 32'd4099);
        last_slip = cyc;
        nslip++;
      end
    end
    check("misaligned_locked", 32'(aligned), 32'd1);
    check("misaligned_slip_cnt", 32'(slip_cnt), 32'd3);
    check("misaligned_slips", 32'(nslip), 32'd3);
    check("model_offset", 32'(off), 32'd0);

    // Data decode while locked
    send(10'h100);
    send(10'h2FF);
    check("dec_0x100", 32'({dout, de}), 32'({8'h00, 1'b1}));
    send(10'h2AB);
    check("dec_0x2FF", 32'({dout, de}), 32'({8'hFE, 1'b1}));
    send(10'h2AB);
    check("dec_token11", 32'({dout, c1, c0, de}), 32'({8'hFE, 1'b1, 1'b1, 1'b0}));

    // Lock loss after TIMEOUT data words
    for (int j = 0; j < 4096; j++) send(rand_data());
    check("lock_held_4096", 32'(aligned), 32'd1);
    send(rand_data());
    check("lock_dropped", 32'({aligned, bitslip, de}), 32'd0);
    send(rand_data());
    check("de_after_drop", 32'(de), 32'd0);

    // Short token runs never lock; reset lands inside SLIP_WAIT
    rot_en = 0; off = 0;
    do_reset();
    nslip = 0; last_slip = 0; acnt = 0;
    for (int t = 0; t < 9000 && nslip < 2; t++) begin
      send(((t % 64) < 63) ? TOKENS[$urandom_range(0, 3)] : rand_data());
      if (aligned) acnt++;
      if (bitslip) begin
        if (nslip == 0) check("short_first_slip", 32'(cyc - rst_cyc), 32'd4096);
        else check("short_slip_spacing", 32'(cyc - last_slip), 32'd4099);
        last_slip = cyc;
        nslip++;
      end
    end
    check("short_never_aligned", 32'(acnt), 32'd0);
    check("short_slips", 32'(nslip), 32'd2);
    check("slip_cnt_before_rst", 32'(slip_cnt), 32'd2);
    do_reset();
    check("reset_in_wait", 32'({bitslip, aligned, slip_cnt, dout, c1, c0, de}), 32'd0);
    for (int i = 0; i < 64; i++) send(TOKENS[1]);
    check("relock_edge64", 32'(aligned), 32'd0);
    send(TOKENS[1]);
    check("relock_edge65", 32'(aligned), 32'd1);
    check("relock_ctl", 32'({c1, c0}), 32'd1);

    // Randomized traffic with rotation, mixed tokens and occasional resets
    rot_en = 1;
    for (int s = 0; s < 24; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) off = int'($urandom_range(0, 9));
      tk = TOKENS[$urandom_range(0, 3)];
      n = int'($urandom_range(1, 160));
      for (int i = 0; i < n; i++)
        send(($urandom_range(0, 7) == 0) ? TOKENS[$urandom_range(0, 3)] : tk);
      n = int'($urandom_range(1, 300));
      for (int i = 0; i < n; i++) send(rand_data());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
